// File: rtl/id_ex_operand_stage.sv
// ID->EX operand register: forwards EX/MEM and MEM/WB results over regfile data,
// bubbles on load-use, and counts the cycles ID is held back.

module id_ex_fwd_src #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             use_src,
  input  logic [WIDTH-1:0] rdata,
  input  logic             ex_valid,
  input  logic             ex_busy,
  input  logic [SEL_W-1:0] ex_sel,
  input  logic [WIDTH-1:0] ex_data,
  input  logic             wb_valid,
  input  logic [SEL_W-1:0] wb_sel,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             ld_pending,
  input  logic [SEL_W-1:0] ld_sel,
  output logic [WIDTH-1:0] op,
  output logic             blocked
);
  logic ex_match, wb_hit;

  assign ex_match = ex_valid & (ex_sel == sel);
  assign wb_hit   = wb_valid & (wb_sel == sel);

  // The youngest producer wins; a busy EX/MEM load has no data to give yet.
  assign op = (ex_match & ~ex_busy) ? ex_data :
              wb_hit                ? wb_data : rdata;

  assign blocked = use_src & ((ld_pending & (ld_sel == sel)) | (ex_match & ex_busy));
endmodule

module id_ex_operand_stage #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_rs1Sel,
  input  logic [SEL_W-1:0] in_rs2Sel,
  input  logic             in_useRs1,
  input  logic             in_useRs2,
  input  logic [SEL_W-1:0] in_rdSel,
  input  logic             in_rdWrite,
  input  logic             in_isLoad,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [WIDTH-1:0] read1Data,
  input  logic [WIDTH-1:0] read2Data,
  input  logic             exFwdValid,
  input  logic             exFwdBusy,
  input  logic [SEL_W-1:0] exFwdSel,
  input  logic [WIDTH-1:0] exFwdData,
  input  logic             wbFwdValid,
  input  logic [SEL_W-1:0] wbFwdSel,
  input  logic [WIDTH-1:0] wbFwdData,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_op1,
  output logic [WIDTH-1:0] out_op2,
  output logic [SEL_W-1:0] out_rdSel,
  output logic             out_rdWrite,
  output logic             out_isLoad,
  output logic [WIDTH-1:0] out_imm,
  output logic [CNT_W-1:0] stallCount
);
  typedef struct packed {
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [SEL_W-1:0] rd_sel;
    logic             rd_write;
    logic             is_load;
    logic [WIDTH-1:0] imm;
  } payload_t;

  payload_t              pl, pl_in;
  logic                  valid;
  logic [1:0][SEL_W-1:0] src_sel;
  logic [1:0]            src_use, src_blk;
  logic [1:0][WIDTH-1:0] src_rdata, src_op;
  logic                  ld_pending, hazard, adv, take;

  assign src_sel    = {in_rs2Sel, in_rs1Sel};
  assign src_use    = {in_useRs2, in_useRs1};
  assign src_rdata  = {read2Data, read1Data};
  assign ld_pending = valid & pl.is_load & pl.rd_write;

  for (genvar g = 0; g < 2; g++) begin : g_src
    id_ex_fwd_src #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_src (
      .sel(src_sel[g]), .use_src(src_use[g]), .rdata(src_rdata[g]),
      .ex_valid(exFwdValid), .ex_busy(exFwdBusy), .ex_sel(exFwdSel), .ex_data(exFwdData),
      .wb_valid(wbFwdValid), .wb_sel(wbFwdSel), .wb_data(wbFwdData),
      .ld_pending(ld_pending), .ld_sel(pl.rd_sel),
      .op(src_op[g]), .blocked(src_blk[g])
    );
  end

  assign hazard   = in_valid & (|src_blk);
  assign adv      = ~valid | out_ready;
  assign in_ready = adv & ~hazard & ~flush;
  assign take     = in_valid & ~hazard;

  assign pl_in = '{op1: src_op[0], op2: src_op[1], rd_sel: in_rdSel,
                   rd_write: in_rdWrite, is_load: in_isLoad, imm: in_imm};

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pl    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (adv) begin
      // A hazard with room downstream becomes a bubble; ID keeps its instruction.
      valid <= take;
      if (take) pl <= pl_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stallCount <= '0;
    else if (in_valid & ~in_ready & ~flush & ~(&stallCount))
      stallCount <= stallCount + 1'b1;
  end

  assign out_valid   = valid;
  assign out_op1     = pl.op1;
  assign out_op2     = pl.op2;
  assign out_rdSel   = pl.rd_sel;
  assign out_rdWrite = pl.rd_write;
  assign out_isLoad  = pl.is_load;
  assign out_imm     = pl.imm;
endmodule
